// File: rtl/eb_width_downsizer.sv
// Elastic valid/ready downsizer: holds one wide word and emits its lanes one per cycle, lane 0 first.
// Optional lane masking is enabled by defining EB_DWS_LANE_MASK_EN.
module eb_width_downsizer #(
    parameter int LANE_WIDTH = 16,
    parameter int LANES      = 4,
    localparam int IDX_W     = (LANES > 1) ? $clog2(LANES) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        valid_in,
    output logic                        ready_out,
    input  logic [LANES*LANE_WIDTH-1:0] data_in,
`ifdef EB_DWS_LANE_MASK_EN
    input  logic [LANES-1:0]            mask_in,
`endif
    output logic                        valid_out,
    input  logic                        ready_in,
    output logic [LANE_WIDTH-1:0]       data_out,
    output logic [IDX_W-1:0]            lane_idx_out,
    output logic                        last_out
);

    // Handshake: a transfer happens on a rising clk edge when valid and ready are both high;
    // valid never waits on ready, and ready_out may depend combinationally on ready_in.

    logic                        r_full;
    logic [IDX_W-1:0]            r_idx;
    logic [LANES*LANE_WIDTH-1:0] r_word;

    logic                        w_accept;
    logic                        w_take;
    logic                        w_last;
    logic                        w_load_full;
    logic [IDX_W-1:0]            w_first;
    logic [IDX_W-1:0]            w_next;
    logic [LANE_WIDTH-1:0]       w_data;

`ifdef EB_DWS_LANE_MASK_EN
    logic [LANES-1:0] r_mask;
    logic             w_has_next;

    // Downward scans so the lowest qualifying lane wins.
    always_comb begin
        w_first    = '0;
        w_next     = '0;
        w_has_next = 1'b0;
        for (int k = LANES - 1; k >= 0; k--) begin
            if (mask_in[k]) begin
                w_first = k[IDX_W-1:0];
            end
            if (r_mask[k] && (k > int'(r_idx))) begin
                w_next     = k[IDX_W-1:0];
                w_has_next = 1'b1;
            end
        end
    end

    assign w_last      = ~w_has_next;
    assign w_load_full = |mask_in;
`else
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    assign w_first     = '0;
    assign w_next      = r_idx + IDX_W'(1);
    assign w_last      = (r_idx == LAST_IDX);
    assign w_load_full = 1'b1;
`endif

    always_comb begin
        w_data = '0;
        for (int k = 0; k < LANES; k++) begin
            if (r_idx == k[IDX_W-1:0]) begin
                w_data = r_word[k*LANE_WIDTH +: LANE_WIDTH];
            end
        end
    end

    assign valid_out    = r_full;
    assign data_out     = w_data;
    assign lane_idx_out = r_idx;
    assign last_out     = r_full & w_last;

    // Accepting alongside the final take keeps the output stream bubble-free.
    assign ready_out = ~r_full | (ready_in & last_out);
    assign w_accept  = valid_in & ready_out;
    assign w_take    = valid_out & ready_in;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_full <= 1'b0;
            r_idx  <= '0;
`ifdef EB_DWS_LANE_MASK_EN
            r_mask <= '0;
`endif
        end else if (w_accept) begin
            r_full <= w_load_full;
            r_idx  <= w_load_full ? w_first : '0;
`ifdef EB_DWS_LANE_MASK_EN
            r_mask <= mask_in;
`endif
        end else if (w_take) begin
            if (last_out) begin
                r_full <= 1'b0;
                r_idx  <= '0;
            end else begin
                r_idx  <= w_next;
            end
        end
    end

    // The word itself needs no reset: it is only observed while r_full is set.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_word <= data_in;
        end
    end

endmodule

// File: tb/tb_eb_width_downsizer.sv
// Bench for eb_width_downsizer (LANES=4, LANE_WIDTH=16): directed steps then random traffic,
// checked against a queue of expected lanes {last, idx, data}.
module tb_eb_width_downsizer;

  localparam int LW    = 16;
  localparam int LANES = 4;
  localparam int IDX_W = 2;
  localparam int W     = 1 + IDX_W + LW;

  logic                clk;
  logic                rst;
  logic                valid_in;
  logic                ready_out;
  logic [LANES*LW-1:0] data_in;
`ifdef EB_DWS_LANE_MASK_EN
  logic [LANES-1:0]    mask_in;
`endif
  logic                valid_out;
  logic                ready_in;
  logic [LW-1:0]       data_out;
  logic [IDX_W-1:0]    lane_idx_out;
  logic                last_out;

  int checks   = 0;
  int failures = 0;

  logic [W-1:0] exp_q[$];

  eb_width_downsizer #(.LANE_WIDTH(LW), .LANES(LANES)) dut (
    .clk          (clk),
    .rst          (rst),
    .valid_in     (valid_in),
    .ready_out    (ready_out),
    .data_in      (data_in),
`ifdef EB_DWS_LANE_MASK_EN
    .mask_in      (mask_in),
`endif
    .valid_out    (valid_out),
    .ready_in     (ready_in),
    .data_out     (data_out),
    .lane_idx_out (lane_idx_out),
    .last_out     (last_out)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: the enabled lanes of a word, lowest first; the highest enabled one is last.
  task automatic push_word(input logic [63:0] d, input logic [3:0] m);
    int hi;
    logic [1:0] ix;
    hi = -1;
    for (int k = 0; k < LANES; k++) if (m[k]) hi = k;
    for (int k = 0; k < LANES; k++) begin
      if (m[k]) begin
        ix = 2'(k);
        exp_q.push_back({(k == hi), ix, d[k*LW +: LW]});
      end
    end
  endtask

  // driver: one clock cycle with the given inputs, outputs checked at the falling edge
  task automatic cycle(input logic vin, input logic [63:0] din, input logic [3:0] m,
                       input logic rin);
    logic exp_valid;
    logic exp_ready;
    logic [3:0] eff_m;
    logic [W-1:0] h;
`ifdef EB_DWS_LANE_MASK_EN
    eff_m   = m;
    mask_in = m;
`else
    eff_m   = 4'hF;
`endif
    valid_in = vin;
    data_in  = din;
    ready_in = rin;
    @(negedge clk);
    exp_valid = (exp_q.size() > 0);
    exp_ready = (exp_q.size() == 0) || (rin && exp_q.size() == 1);
    check("valid_out", 64'(valid_out), 64'(exp_valid));
    check("ready_out", 64'(ready_out), 64'(exp_ready));
    if (exp_valid) begin
      h = exp_q[0];
      check("data_out", 64'(data_out), 64'(h[LW-1:0]));
      check("lane_idx", 64'(lane_idx_out), 64'(h[LW +: IDX_W]));
      check("last_out", 64'(last_out), 64'(h[W-1]));
    end else begin
      check("idle_idx", 64'(lane_idx_out), 64'd0);
      check("idle_last", 64'(last_out), 64'd0);
    end
    @(posedge clk);
    if (exp_valid && rin) void'(exp_q.pop_front());
    if (vin && exp_ready) push_word(din, eff_m);
    #1;
  endtask

  task automatic idle(input int n, input logic rin);
    for (int i = 0; i < n; i++) cycle(1'b0, 64'd0, 4'hF, rin);
  endtask

  initial begin
    logic [63:0] wa;
    logic [63:0] wb;
    rst      = 1'b1;
    valid_in = 1'b0;
    data_in  = '0;
    ready_in = 1'b0;
`ifdef EB_DWS_LANE_MASK_EN
    mask_in  = 4'hF;
`endif
    // reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 64'(valid_out), 64'd0);
    check("rst_ready", 64'(ready_out), 64'd1);
    check("rst_idx", 64'(lane_idx_out), 64'd0);
    check("rst_last", 64'(last_out), 64'd0);
    rst = 1'b0;
    idle(2, 1'b1);

    // single word, consumer always ready
    cycle(1'b1, 64'h4444_3333_2222_1111, 4'hF, 1'b1);
    idle(5, 1'b1);

    // back-to-back words held on valid_in
    wa = 64'hAAA4_AAA3_AAA2_AAA1;
    wb = 64'hBBB4_BBB3_BBB2_BBB1;
    cycle(1'b1, wa, 4'hF, 1'b1);
    for (int i = 0; i < 4; i++) cycle(1'b1, (exp_q.size() == 0) ? wa : wb, 4'hF, 1'b1);
    idle(5, 1'b1);

    // backpressure on lane 1
    cycle(1'b1, 64'h4444_3333_2222_1111, 4'hF, 1'b1);
    cycle(1'b0, 64'd0, 4'hF, 1'b1);
    idle(3, 1'b0);
    idle(4, 1'b1);

`ifdef EB_DWS_LANE_MASK_EN
    // masked lanes are skipped; an empty mask drops the word
    cycle(1'b1, 64'h4444_3333_2222_1111, 4'b1010, 1'b1);
    idle(3, 1'b1);
    cycle(1'b1, 64'h9999_8888_7777_6666, 4'b0000, 1'b1);
    cycle(1'b1, 64'h4444_3333_2222_1111, 4'b0100, 1'b1);
    idle(3, 1'b1);
`endif

    // asynchronous reset while lane 2 is pending
    cycle(1'b1, 64'hDDD4_DDD3_DDD2_DDD1, 4'hF, 1'b1);
    idle(2, 1'b1);
    ready_in = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("arst_valid", 64'(valid_out), 64'd0);
    check("arst_ready", 64'(ready_out), 64'd1);
    check("arst_idx", 64'(lane_idx_out), 64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    idle(2, 1'b1);

    // random traffic
    for (int i = 0; i < 500; i++) begin
      cycle(($urandom_range(0, 9) < 7), {$urandom(), $urandom()},
            4'($urandom_range(0, 15)), ($urandom_range(0, 9) < 7));
    end
    idle(6, 1'b1);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
